// File: rtl/corr_pkg.sv
// Shared types for the correlation-window controller.
//   corr_state_t : sequencer states (STALL is only reachable when
//                  CORR_WINDOW_CTRL_STALL_EN is defined)
//   corr_res_t   : one captured window result {x, y, isect, symdiff, len, seq}
package corr_pkg;

  localparam int unsigned CORR_TIME_W = 8;
  localparam int unsigned CORR_SEQ_W  = 8;
  localparam int unsigned CORR_DROP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } corr_state_t;

  typedef struct packed {
    logic [CORR_TIME_W-1:0] x;
    logic [CORR_TIME_W-1:0] y;
    logic [CORR_TIME_W-1:0] isect;
    logic [CORR_TIME_W-1:0] symdiff;
    logic [CORR_TIME_W-1:0] len;
    logic [CORR_SEQ_W-1:0]  seq;
  } corr_res_t;

endpackage

// File: rtl/corr_result_slot.sv
// One-entry result holding register with a valid/ready drain port.
//   i_clk, i_arst_n : clock, async active-low reset
//   i_load, i_data  : capture request and payload
//   i_ready         : consumer accepts the held entry
//   o_valid, o_data : held entry (data stays stable until accepted)
//   o_overwrite_c   : a load is replacing an entry nobody accepted
module corr_result_slot
  import corr_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_arst_n,
  input  logic      i_load,
  input  corr_res_t i_data,
  input  logic      i_ready,
  output logic      o_valid,
  output corr_res_t o_data,
  output logic      o_overwrite_c
);

  logic      r_valid;
  corr_res_t r_data;

  // Load wins over accept so a same-cycle accept+load keeps valid high.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid       = r_valid;
  assign o_data        = r_data;
  assign o_overwrite_c = i_load && r_valid && !i_ready;

endmodule

// File: rtl/corr_window_ctrl.sv
// Window sequencer for a correlation counter pair. Runs back-to-back windows
// of programmable length, restarts the counter at each boundary and captures
// its four counts into a one-entry result slot drained by valid/ready.
//   i_clk, i_arst_n       : clock, async active-low reset
//   i_enable              : run windows when high
//   i_windowLen           : window length (0 behaves as 1), sampled at window start
//   o_cg, o_tUpdate       : counter clock-gate and restart strobe
//   o_tValue              : restart value for the counter (always 0)
//   i_count*              : counter outputs
//   o_resultValid/i_resultReady, o_res*, o_resLen, o_resSeq : result slot
//   o_dropCount           : saturating count of overwritten results
// Build option: CORR_WINDOW_CTRL_STALL_EN -- a boundary that finds the slot
// full and not accepted freezes the counter in STALL instead of overwriting.
module corr_window_ctrl
  import corr_pkg::*;
#(
  parameter int unsigned TIME_W = CORR_TIME_W,
  parameter int unsigned SEQ_W  = CORR_SEQ_W
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_enable,
  input  logic [TIME_W-1:0]      i_windowLen,
  output logic                   o_cg,
  output logic                   o_tUpdate,
  output logic [TIME_W-1:0]      o_tValue,
  input  logic [TIME_W-1:0]      i_countX,
  input  logic [TIME_W-1:0]      i_countY,
  input  logic [TIME_W-1:0]      i_countIsect,
  input  logic [TIME_W-1:0]      i_countSymdiff,
  output logic                   o_resultValid,
  input  logic                   i_resultReady,
  output logic [TIME_W-1:0]      o_resX,
  output logic [TIME_W-1:0]      o_resY,
  output logic [TIME_W-1:0]      o_resIsect,
  output logic [TIME_W-1:0]      o_resSymdiff,
  output logic [TIME_W-1:0]      o_resLen,
  output logic [SEQ_W-1:0]       o_resSeq,
  output logic [CORR_DROP_W-1:0] o_dropCount
);

  localparam logic [CORR_DROP_W-1:0] DROP_MAX = '1;

  corr_state_t       r_state;
  corr_state_t       w_state_nxt;
  logic [TIME_W-1:0] r_wcnt;
  logic [TIME_W-1:0] w_wcnt_nxt;
  logic [TIME_W-1:0] r_len;
  logic [TIME_W-1:0] w_len_nxt;
  logic              r_first;
  logic              w_first_nxt;
  logic [SEQ_W-1:0]  r_seq;
  logic [SEQ_W-1:0]  w_seq_nxt;

  logic [TIME_W-1:0] w_len_in;
  logic [TIME_W-1:0] w_len_eff;
  logic              w_running;
  logic              w_at_bnd;
  logic              w_hold;
  logic              w_active;
  logic              w_capture;
  logic              w_slot_valid;
  logic              w_overwrite;
  corr_res_t         w_slot_d;
  corr_res_t         w_slot_q;

  // A zero window length is treated as a one-cycle window.
  assign w_len_in = (i_windowLen == '0) ? TIME_W'(1) : i_windowLen;

  // wcnt==0 marks a start/boundary cycle, where the new length takes effect.
  assign w_at_bnd  = w_running && (r_wcnt == '0);
  assign w_len_eff = (r_wcnt == '0) ? w_len_in : r_len;

`ifdef CORR_WINDOW_CTRL_STALL_EN
  assign w_running = (r_state == ST_RUN) || (r_state == ST_STALL);
  // Boundary blocked by an unaccepted result: freeze instead of overwrite.
  assign w_hold    = w_at_bnd && !r_first && w_slot_valid && !i_resultReady;
`else
  assign w_running = (r_state == ST_RUN);
  assign w_hold    = 1'b0;
`endif

  assign w_active  = w_running && !w_hold;
  // The first RUN cycle restarts the counter but has no finished window.
  assign w_capture = w_active && w_at_bnd && !r_first;

  // State register.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Window counter, latched length, start flag and sequence number.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wcnt  <= '0;
      r_len   <= TIME_W'(1);
      r_first <= 1'b0;
      r_seq   <= '0;
    end else begin
      r_wcnt  <= w_wcnt_nxt;
      r_len   <= w_len_nxt;
      r_first <= w_first_nxt;
      r_seq   <= w_seq_nxt;
    end
  end

  // Next-state and window-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_len_nxt   = r_len;
    w_first_nxt = r_first;
    w_seq_nxt   = r_seq;

    if (w_capture) begin
      w_seq_nxt = r_seq + SEQ_W'(1);
    end

    case (r_state)
      ST_IDLE: begin
        w_wcnt_nxt  = '0;
        w_first_nxt = 1'b0;
        if (i_enable) begin
          w_state_nxt = ST_RUN;
          w_first_nxt = 1'b1;
        end
      end
      default: begin
        if (!i_enable) begin
          // Partial window is abandoned; a held result stays in the slot.
          w_state_nxt = ST_IDLE;
          w_wcnt_nxt  = '0;
          w_first_nxt = 1'b0;
        end else if (w_hold) begin
          w_state_nxt = ST_STALL;
        end else begin
          w_state_nxt = ST_RUN;
          w_first_nxt = 1'b0;
          if (w_at_bnd) begin
            w_len_nxt = w_len_in;
          end
          if (r_wcnt == w_len_eff - TIME_W'(1)) begin
            w_wcnt_nxt = '0;
          end else begin
            w_wcnt_nxt = r_wcnt + TIME_W'(1);
          end
        end
      end
    endcase
  end

  // Counter control decodes.
  always_comb begin
    o_cg      = 1'b0;
    o_tUpdate = 1'b0;
    if (w_active) begin
      o_cg      = 1'b1;
      o_tUpdate = (r_wcnt == '0);
    end
  end

  assign o_tValue = '0;

  // Result captured at the boundary carries the window that just closed.
  always_comb begin
    w_slot_d         = '0;
    w_slot_d.x       = i_countX;
    w_slot_d.y       = i_countY;
    w_slot_d.isect   = i_countIsect;
    w_slot_d.symdiff = i_countSymdiff;
    w_slot_d.len     = r_len;
    w_slot_d.seq     = r_seq + SEQ_W'(1);
  end

  corr_result_slot u_slot (
    .i_clk         (i_clk),
    .i_arst_n      (i_arst_n),
    .i_load        (w_capture),
    .i_data        (w_slot_d),
    .i_ready       (i_resultReady),
    .o_valid       (w_slot_valid),
    .o_data        (w_slot_q),
    .o_overwrite_c (w_overwrite)
  );

  assign o_resultValid = w_slot_valid;
  assign o_resX        = w_slot_q.x;
  assign o_resY        = w_slot_q.y;
  assign o_resIsect    = w_slot_q.isect;
  assign o_resSymdiff  = w_slot_q.symdiff;
  assign o_resLen      = w_slot_q.len;
  assign o_resSeq      = w_slot_q.seq;

`ifdef CORR_WINDOW_CTRL_STALL_EN
  // Stalling guarantees no result is ever overwritten.
  logic w_unused_ovr;
  assign w_unused_ovr = w_overwrite;
  assign o_dropCount  = '0;
`else
  logic [CORR_DROP_W-1:0] r_drop;

  // Saturating overwrite counter; only reset clears it.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_drop <= '0;
    end else if (w_overwrite && (r_drop != DROP_MAX)) begin
      r_drop <= r_drop + CORR_DROP_W'(1);
    end
  end

  assign o_dropCount = r_drop;
`endif

endmodule
